// File: rtl/hog_stream_driver.sv
// Raster pixel source for the hog pipeline with selectable pattern and pacing,
// plus a probe that measures sof-to-first-window latency and counts window handshakes.
module hog_stream_driver #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned IMAGE_WIDTH  = 128,
  parameter int unsigned IMAGE_HEIGHT = 256,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] const_value,
  input  logic [3:0]            throttle,
  input  logic [7:0]            num_frames,
  output logic                  pixel_valid,
  input  logic                  pixel_ready,
  output logic [DATA_WIDTH-1:0] pixel,
  output logic                  sof,
  output logic                  eof,
  input  logic                  window_valid,
  input  logic                  window_ready,
  output logic [CNT_WIDTH-1:0]  latency,
  output logic                  latency_valid,
  output logic [CNT_WIDTH-1:0]  window_count,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned XW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int unsigned YW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam logic [XW-1:0] XLast = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] YLast = YW'(IMAGE_HEIGHT - 1);
  localparam logic [15:0] LfsrTaps = 16'hB400;
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  state_e state_q, state_d;

  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [7:0]            frame_q;
  logic [3:0]            thr_q, thr_d;
  logic                  valid_q, valid_d;
  logic                  load;
  logic [DATA_WIDTH-1:0] pix_q, pix_d;
  logic                  sof_q, eof_q;
  logic                  next_sof, next_eof;
  logic [1:0]            mode_q, mode_sel;

  logic [CNT_WIDTH-1:0]  lat_cnt_q, latency_q, win_cnt_q;
  logic                  lat_run_q, lat_valid_q;

  logic start, xfer, sof_xfer, eof_xfer, win_hs, frames_reached;

  assign start          = (state_q == StIdle) && enable;
  assign xfer           = valid_q && pixel_ready;
  assign sof_xfer       = xfer && sof_q;
  assign eof_xfer       = xfer && eof_q;
  assign win_hs         = window_valid && window_ready;
  assign frames_reached = (num_frames != 8'd0) && ((frame_q + 8'd1) == num_frames);

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state; a frame in progress always runs to its eof handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (enable) state_d = StStream;
      end
      StStream: begin
        if (eof_xfer) begin
          if (frames_reached) begin
            state_d = StDone;
          end else if (!enable) begin
            state_d = StIdle;
          end
        end
      end
      StDone: begin
        if (!enable) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy          = (state_q != StIdle);
    done          = (state_q == StDone);
    pixel_valid   = valid_q;
    pixel         = pix_q;
    sof           = valid_q && sof_q;
    eof           = valid_q && eof_q;
    latency       = latency_q;
    latency_valid = lat_valid_q;
    window_count  = win_cnt_q;
  end

  // Raster position and LFSR advance only on transfers
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    lfsr_d = lfsr_q;
    if (start) begin
      x_d    = '0;
      y_d    = '0;
      lfsr_d = LFSR_SEED;
    end else if (xfer) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);
      if (x_q == XLast) begin
        x_d = '0;
        y_d = (y_q == YLast) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  // Pacing: valid is a register, so it never depends on pixel_ready combinationally
  always_comb begin
    valid_d = valid_q;
    thr_d   = thr_q;
    load    = 1'b0;
    if ((state_q != StStream) || (state_d != StStream)) begin
      valid_d = 1'b0;
      thr_d   = '0;
    end else if (xfer) begin
      if (throttle == 4'd0) begin
        valid_d = 1'b1;
        load    = 1'b1;
      end else begin
        valid_d = 1'b0;
        thr_d   = throttle;
      end
    end else if (!valid_q) begin
      if (thr_q <= 4'd1) begin
        valid_d = 1'b1;
        load    = 1'b1;
        thr_d   = '0;
      end else begin
        thr_d = thr_q - 4'd1;
      end
    end
  end

  // Pixel is captured when it is presented, so it is stable while stalled.
  // The pattern select is latched with each sof pixel and held for the frame.
  always_comb begin
    next_sof = (x_d == '0) && (y_d == '0);
    next_eof = (x_d == XLast) && (y_d == YLast);
    mode_sel = next_sof ? mode : mode_q;
    case (mode_sel)
      2'd0:    pix_d = const_value;
      2'd1:    pix_d = DATA_WIDTH'(x_d) + DATA_WIDTH'(y_d);
      2'd2:    pix_d = lfsr_d[DATA_WIDTH-1:0];
      default: pix_d = {DATA_WIDTH{x_d[0] ^ y_d[0]}};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q     <= '0;
      y_q     <= '0;
      lfsr_q  <= LFSR_SEED;
      frame_q <= '0;
      thr_q   <= '0;
      valid_q <= 1'b0;
      pix_q   <= '0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      mode_q  <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      lfsr_q  <= lfsr_d;
      thr_q   <= thr_d;
      valid_q <= valid_d;
      if (load) begin
        pix_q  <= pix_d;
        sof_q  <= next_sof;
        eof_q  <= next_eof;
        mode_q <= mode_sel;
      end
      if (start) begin
        frame_q <= '0;
      end else if (eof_xfer) begin
        frame_q <= frame_q + 8'd1;
      end
    end
  end

  // lat_cnt_q holds cycles elapsed since the sof transfer; sof restarts a pending
  // measurement and masks any window handshake in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_cnt_q   <= '0;
      lat_run_q   <= 1'b0;
      latency_q   <= '0;
      lat_valid_q <= 1'b0;
      win_cnt_q   <= '0;
    end else begin
      lat_valid_q <= 1'b0;
      if (sof_xfer) begin
        lat_cnt_q <= CNT_WIDTH'(1);
        lat_run_q <= 1'b1;
      end else if (lat_run_q) begin
        if (win_hs) begin
          latency_q   <= lat_cnt_q;
          lat_valid_q <= 1'b1;
          lat_run_q   <= 1'b0;
        end else if (lat_cnt_q != CntMax) begin
          lat_cnt_q <= lat_cnt_q + CNT_WIDTH'(1);
        end
      end
      if (start) begin
        win_cnt_q <= '0;
      end else if (busy && win_hs && (win_cnt_q != CntMax)) begin
        win_cnt_q <= win_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_hog_stream_driver.sv
// Randomised bench for hog_stream_driver on a 4x2 image, checked against a raster/pattern
// model that derives each expected pixel from its index within the frame.
module tb_hog_stream_driver;

  localparam int unsigned DW   = 8;
  localparam int unsigned W    = 4;
  localparam int unsigned H    = 2;
  localparam int unsigned CW   = 8;
  localparam int unsigned NPIX = W * H;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          rst, enable, pixel_ready, window_valid, window_ready;
  logic [1:0]    mode;
  logic [DW-1:0] const_value;
  logic [3:0]    throttle;
  logic [7:0]    num_frames;
  logic          pixel_valid, sof, eof, latency_valid, busy, done;
  logic [DW-1:0] pixel;
  logic [CW-1:0] latency, window_count;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  hog_stream_driver #(
    .DATA_WIDTH  (DW),
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .LFSR_SEED   (SEED),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .mode         (mode),
    .const_value  (const_value),
    .throttle     (throttle),
    .num_frames   (num_frames),
    .pixel_valid  (pixel_valid),
    .pixel_ready  (pixel_ready),
    .pixel        (pixel),
    .sof          (sof),
    .eof          (eof),
    .window_valid (window_valid),
    .window_ready (window_ready),
    .latency      (latency),
    .latency_valid(latency_valid),
    .window_count (window_count),
    .busy         (busy),
    .done         (done)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  // Expected pixel for the idx-th transfer since the stream started
  function automatic logic [DW-1:0] ref_pix(input int m, input int idx, input logic [DW-1:0] cv,
                                            input logic [15:0] lf);
    int x, y;
    x = idx % W;
    y = (idx / W) % H;
    case (m)
      0:       return cv;
      1:       return DW'(x + y);
      2:       return lf[DW-1:0];
      default: return ((x + y) % 2 == 1) ? {DW{1'b1}} : '0;
    endcase
  endfunction

  task automatic quiesce();
    int t;
    enable = 1'b0; window_valid = 1'b0; window_ready = 1'b0; pixel_ready = 1'b1;
    t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fails++;
      $display("FAIL quiesce: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({pixel_valid, sof, eof, busy, done, latency_valid} !== 6'b0) begin
      n_fails++;
      $display("FAIL reset_flags: got %b required 000000",
               {pixel_valid, sof, eof, busy, done, latency_valid});
    end
    n_checks++;
    if (pixel !== '0) begin
      n_fails++;
      $display("FAIL reset_pixel: got %h required 00", pixel);
    end
    n_checks++;
    if ({latency, window_count} !== '0) begin
      n_fails++;
      $display("FAIL reset_counters: got %h/%h required 0/0", latency, window_count);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || pixel_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_release_idle: busy=%b valid=%b required 0 0", busy, pixel_valid);
    end
  endtask

  task automatic test_ramp_frame();
    int ntx, eof_k;
    logic [DW-1:0] ep;
    logic es, ee;
    mode = 2'd1; throttle = 4'd0; num_frames = 8'd1; pixel_ready = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    ntx = 0; eof_k = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_checks++;
        if (busy !== 1'b1 || pixel_valid !== 1'b0) begin
          n_fails++;
          $display("FAIL ramp_enter: busy=%b valid=%b required 1 0", busy, pixel_valid);
        end
      end
      if (k == 2) begin
        n_checks++;
        if (pixel_valid !== 1'b1) begin
          n_fails++;
          $display("FAIL ramp_first_valid: valid=%b required 1", pixel_valid);
        end
      end
      if (eof_k > 0 && k == eof_k + 1) begin
        n_checks++;
        if (done !== 1'b1 || pixel_valid !== 1'b0) begin
          n_fails++;
          $display("FAIL ramp_done: done=%b valid=%b required 1 0", done, pixel_valid);
        end
      end
      if (pixel_valid && pixel_ready) begin
        ep = ref_pix(1, ntx, const_value, 16'h0);
        es = (ntx % NPIX == 0);
        ee = (ntx % NPIX == NPIX - 1);
        n_checks++;
        if ({pixel, sof, eof} !== {ep, es, ee} || k != ntx + 2) begin
          n_fails++;
          $display("FAIL ramp_pixel[%0d]: got %h sof=%b eof=%b at %0d required %h %b %b at %0d",
                   ntx, pixel, sof, eof, k, ep, es, ee, ntx + 2);
        end
        ntx++;
        if (ntx == NPIX) eof_k = k;
      end
    end
    n_checks++;
    if (ntx != NPIX) begin
      n_fails++;
      $display("FAIL ramp_count: got %0d required %0d", ntx, NPIX);
    end
    quiesce();
  endtask

  task automatic test_throttle();
    int ntx, k0;
    logic [DW-1:0] cv;
    logic ev;
    cv = DW'($urandom);
    const_value = cv; mode = 2'd0; throttle = 4'd2; num_frames = 8'd1; pixel_ready = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    ntx = 0; k0 = -1;
    for (int k = 1; k <= 60 && ntx < NPIX; k++) begin
      @(negedge clk);
      if (k0 < 0 && pixel_valid) k0 = k;
      if (k0 >= 0) begin
        ev = ((k - k0) % 3 == 0);
        n_checks++;
        if (pixel_valid !== ev) begin
          n_fails++;
          $display("FAIL throttle_pacing: cycle %0d valid=%b required %b", k - k0, pixel_valid, ev);
        end
        if (pixel_valid) begin
          n_checks++;
          if ({pixel, sof, eof} !== {cv, (ntx == 0), (ntx == NPIX - 1)}) begin
            n_fails++;
            $display("FAIL throttle_pixel[%0d]: got %h %b %b required %h", ntx, pixel, sof, eof, cv);
          end
          ntx++;
        end
      end
    end
    n_checks++;
    if (ntx != NPIX) begin
      n_fails++;
      $display("FAIL throttle_count: got %0d required %0d", ntx, NPIX);
    end
    quiesce();
  endtask

  task automatic test_lfsr_backpressure();
    logic [15:0] rl;
    logic [DW+1:0] held;
    logic stall;
    int ntx;
    rl = SEED;
    mode = 2'd2; throttle = 4'($urandom_range(0, 1)); num_frames = 8'd2; pixel_ready = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    ntx = 0; stall = 1'b0; held = '0;
    for (int k = 0; k < 400 && ntx < 2 * NPIX; k++) begin
      @(negedge clk);
      if (stall) begin
        n_checks++;
        if (pixel_valid !== 1'b1 || {pixel, sof, eof} !== held) begin
          n_fails++;
          $display("FAIL lfsr_hold: valid=%b data=%h required 1 %h", pixel_valid,
                   {pixel, sof, eof}, held);
        end
      end
      pixel_ready = 1'($urandom_range(0, 1));
      if (pixel_valid && pixel_ready) begin
        n_checks++;
        if ({pixel, sof, eof} !== {rl[DW-1:0], (ntx % NPIX == 0), (ntx % NPIX == NPIX - 1)}) begin
          n_fails++;
          $display("FAIL lfsr_pixel[%0d]: got %h %b %b required %h", ntx, pixel, sof, eof,
                   rl[DW-1:0]);
        end
        rl = lfsr_next(rl);
        ntx++;
        stall = 1'b0;
      end else begin
        stall = pixel_valid;
        held  = {pixel, sof, eof};
      end
    end
    n_checks++;
    if (ntx != 2 * NPIX) begin
      n_fails++;
      $display("FAIL lfsr_count: got %0d required %0d", ntx, 2 * NPIX);
    end
    pixel_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1) begin
      n_fails++;
      $display("FAIL lfsr_done: done=%b required 1", done);
    end
    quiesce();
  endtask

  task automatic test_mode_hold();
    int ntx, m;
    logic [DW-1:0] cv, ep;
    cv = DW'($urandom);
    const_value = cv; mode = 2'd3; throttle = 4'd0; num_frames = 8'd2; pixel_ready = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    ntx = 0;
    for (int k = 0; k < 40 && ntx < 2 * NPIX; k++) begin
      @(negedge clk);
      if (pixel_valid && pixel_ready) begin
        m  = (ntx < NPIX) ? 3 : 0;
        ep = ref_pix(m, ntx, cv, 16'h0);
        n_checks++;
        if (pixel !== ep) begin
          n_fails++;
          $display("FAIL mode_hold[%0d]: got %h required %h", ntx, pixel, ep);
        end
        ntx++;
        if (ntx == 2) mode = 2'd0;
      end
    end
    n_checks++;
    if (ntx != 2 * NPIX) begin
      n_fails++;
      $display("FAIL mode_hold_count: got %0d required %0d", ntx, 2 * NPIX);
    end
    quiesce();
  endtask

  task automatic test_latency();
    int sof_k, pulses, pulse_k;
    logic [CW-1:0] pulse_val;
    mode = 2'd1; throttle = 4'd0; num_frames = 8'd1; pixel_ready = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    sof_k = -1; pulses = 0; pulse_k = -1; pulse_val = '0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (latency_valid) begin
        pulses++;
        pulse_k   = k;
        pulse_val = latency;
      end
      if (sof_k < 0 && pixel_valid && sof) sof_k = k;
      window_valid = (sof_k >= 0) && (k == sof_k || k == sof_k + 20 || k == sof_k + 40);
      window_ready = (sof_k >= 0) && (k == sof_k || k == sof_k + 40);
    end
    window_valid = 1'b0; window_ready = 1'b0;
    n_checks++;
    if (pulses != 1 || pulse_k != sof_k + 41) begin
      n_fails++;
      $display("FAIL latency_pulse: %0d pulses at %0d required 1 at %0d", pulses, pulse_k,
               sof_k + 41);
    end
    n_checks++;
    if (pulse_val !== CW'(40) || latency !== CW'(40)) begin
      n_fails++;
      $display("FAIL latency_value: got %0d/%0d required 40", pulse_val, latency);
    end
    n_checks++;
    if (window_count !== CW'(2)) begin
      n_fails++;
      $display("FAIL window_count: got %0d required 2", window_count);
    end
    quiesce();
  endtask

  task automatic test_latency_saturation();
    int sof_k, pulses;
    logic [CW-1:0] pulse_val;
    mode = 2'd0; throttle = 4'd0; num_frames = 8'd1; pixel_ready = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    sof_k = -1; pulses = 0; pulse_val = '0;
    for (int k = 0; k < 320; k++) begin
      @(negedge clk);
      if (latency_valid) begin
        pulses++;
        pulse_val = latency;
      end
      if (sof_k < 0 && pixel_valid && sof) sof_k = k;
      window_valid = (sof_k >= 0) && (k == sof_k + 300);
      window_ready = window_valid;
    end
    window_valid = 1'b0; window_ready = 1'b0;
    n_checks++;
    if (pulses != 1 || pulse_val !== {CW{1'b1}}) begin
      n_fails++;
      $display("FAIL latency_saturate: %0d pulses value %0d required 1 pulse value %0d", pulses,
               pulse_val, {CW{1'b1}});
    end
    n_checks++;
    if (window_count !== CW'(1)) begin
      n_fails++;
      $display("FAIL window_count_restart: got %0d required 1", window_count);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] rl;
    int ntx;
    mode = 2'd2; throttle = 4'd0; num_frames = 8'd0; pixel_ready = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    repeat (7) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({pixel_valid, sof, eof, busy, done, latency_valid} !== 6'b0 || pixel !== '0) begin
      n_fails++;
      $display("FAIL async_reset_flags: got %b pixel %h required 000000 00",
               {pixel_valid, sof, eof, busy, done, latency_valid}, pixel);
    end
    n_checks++;
    if ({latency, window_count} !== '0) begin
      n_fails++;
      $display("FAIL async_reset_counters: got %0d/%0d required 0/0", latency, window_count);
    end
    @(negedge clk);
    rst = 1'b1;
    rl = SEED; ntx = 0;
    for (int k = 0; k < 30 && ntx < NPIX; k++) begin
      @(negedge clk);
      if (pixel_valid && pixel_ready) begin
        n_checks++;
        if ({pixel, sof, eof} !== {rl[DW-1:0], (ntx == 0), (ntx == NPIX - 1)}) begin
          n_fails++;
          $display("FAIL async_restart[%0d]: got %h %b %b required %h", ntx, pixel, sof, eof,
                   rl[DW-1:0]);
        end
        rl = lfsr_next(rl);
        ntx++;
      end
    end
    n_checks++;
    if (ntx != NPIX) begin
      n_fails++;
      $display("FAIL async_restart_count: got %0d required %0d", ntx, NPIX);
    end
    quiesce();
  endtask

  task automatic test_continuous_stop();
    int ntx, last_k;
    logic [DW-1:0] ep;
    mode = 2'd1; throttle = 4'd0; num_frames = 8'd0; pixel_ready = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    ntx = 0; last_k = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (last_k >= 0 && k == last_k + 1) begin
        n_checks++;
        if (busy !== 1'b0 || pixel_valid !== 1'b0) begin
          n_fails++;
          $display("FAIL stop_idle: busy=%b valid=%b required 0 0", busy, pixel_valid);
        end
      end
      if (pixel_valid && pixel_ready) begin
        ep = ref_pix(1, ntx, const_value, 16'h0);
        n_checks++;
        if ({pixel, sof, eof} !== {ep, (ntx % NPIX == 0), (ntx % NPIX == NPIX - 1)}) begin
          n_fails++;
          $display("FAIL stop_pixel[%0d]: got %h %b %b required %h", ntx, pixel, sof, eof, ep);
        end
        ntx++;
        if (ntx == NPIX + 3) enable = 1'b0;
        if (ntx == 2 * NPIX) last_k = k;
      end
    end
    n_checks++;
    if (ntx != 2 * NPIX || busy !== 1'b0) begin
      n_fails++;
      $display("FAIL stop_count: got %0d transfers busy=%b required %0d busy=0", ntx, busy,
               2 * NPIX);
    end
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; mode = 2'd0; const_value = '0; throttle = 4'd0;
    num_frames = 8'd0; pixel_ready = 1'b0; window_valid = 1'b0; window_ready = 1'b0;
    test_reset();
    test_ramp_frame();
    test_throttle();
    test_lfsr_backpressure();
    test_mode_hold();
    test_latency();
    test_latency_saturation();
    test_async_reset();
    test_continuous_stop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/hog_stream_driver.md
Name: hog_stream_driver

Overview:
Synthesisable pixel-stream source and latency probe for the hog pipeline. It drives raster frames of IMAGE_WIDTH x IMAGE_HEIGHT pixels into the hog pixel input using a valid/ready handshake, with selectable pattern and throttle. It watches the hog window output handshake and reports per-frame latency and the window count. It sits in front of hog on the FPGA bring-up build, so on-chip measurements do not need a host stimulus.

Parameters:
DATA_WIDTH, 8, pixel width (legal range 1..16)
IMAGE_WIDTH, 128, pixels per line
IMAGE_HEIGHT, 256, lines per frame
LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)
CNT_WIDTH, 32, width of the latency and window counters

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
enable  in  1  start streaming; sampled in IDLE only
mode  in  2  pattern select: 0 constant, 1 ramp, 2 LFSR, 3 checkerboard
const_value  in  DATA_WIDTH  pixel value used in mode 0
throttle  in  4  number of idle cycles inserted after each accepted pixel
num_frames  in  8  frames to send; 0 means continuous
pixel_valid  out  1  pixel output valid
pixel_ready  in  1  hog accepts the pixel
pixel  out  DATA_WIDTH  pixel data
sof  out  1  high together with the first pixel of each frame
eof  out  1  high together with the last pixel of each frame
window_valid  in  1  hog window valid (observed only)
window_ready  in  1  window consumer ready (observed only)
latency  out  CNT_WIDTH  last measured latency in cycles
latency_valid  out  1  one-cycle pulse when latency updates
window_count  out  CNT_WIDTH  number of window handshakes since enable
busy  out  1  high outside IDLE
done  out  1  high in DONE

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs are 0, except that the LFSR is loaded with LFSR_SEED. The x, y, frame and throttle counters are 0.
- FSM states and transitions:
  - IDLE to STREAM on enable=1. Entering STREAM clears window_count and the frame counter and reloads the LFSR.
  - STREAM to DONE after the eof handshake of frame num_frames, when num_frames is not 0.
  - STREAM to IDLE after any eof handshake if enable=0 at that moment. A frame in progress always completes.
  - DONE to IDLE when enable=0.
- Handshake:
  - A pixel transfers when pixel_valid and pixel_ready are both high on the same clock edge.
  - Once pixel_valid is high, pixel, sof and eof stay stable until the transfer.
  - pixel_valid never depends combinationally on pixel_ready.
  - First pixel_valid appears 1 cycle after entering STREAM.
  - After a transfer, pixel_valid is low for exactly throttle cycles. With throttle=0 and pixel_ready held high, one pixel transfers per cycle.
- Raster order: x increments on each transfer. When x reaches IMAGE_WIDTH-1, x wraps to 0 and y increments. At x=IMAGE_WIDTH-1 and y=IMAGE_HEIGHT-1 the pixel carries eof, and the next pixel (x=0, y=0) carries sof.
- Patterns (results truncated to DATA_WIDTH bits):
  - mode 0: const_value.
  - mode 1: (x+y) mod 2^DATA_WIDTH.
  - mode 2: lfsr[DATA_WIDTH-1:0]. Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, shift taps 16'hB400, advancing once per transfer only.
  - mode 3: all ones when x[0] XOR y[0] is 1, else 0.
  - mode is sampled at each sof transfer and held for the whole frame.
- Latency:
  - The counter starts at 0 on the sof transfer and increments every cycle.
  - It stops at the first window handshake (window_valid and window_ready both high) strictly after the sof cycle. Then latency = counter value and latency_valid pulses.
  - A window handshake in the same cycle as the sof transfer is ignored for latency.
  - If a new sof arrives before a window, the pending measurement is discarded and restarted.
  - The counter saturates at all ones.
- window_count increments on every window handshake while busy. It saturates at all ones.
- busy equals (state != IDLE). done stays high in DONE until enable falls.

Test Plan:
- throttle=0, pixel_ready=1, mode=1, IMAGE_WIDTH=4, IMAGE_HEIGHT=2, num_frames=1 -> pixels 0,1,2,3,1,2,3,4; sof on the first, eof on the 8th; done 1 cycle after eof.
- throttle=2, pixel_ready=1 -> pixel_valid high 1 cycle, low 2 cycles, repeating; 3 cycles per pixel.
- mode=2, pixel_ready toggling randomly -> output sequence equals a reference LFSR advanced on transfers only; pixel held stable while stalled.
- sof transfer at cycle T, window handshake at cycle T+40 -> latency=40, a single latency_valid pulse, window_count=1.
- rst driven low mid-frame, asynchronously between edges -> all outputs 0 immediately; after release and enable=1, the frame restarts at x=0, y=0 with sof and the LFSR at LFSR_SEED.
- num_frames=0 with enable dropped mid-frame 2 -> frame 2 completes through eof, then IDLE with busy=0.
